gshare_predictor: RTL

Branch direction predictor that answers the fetch stage's same-cycle prediction request and absorbs resolved-branch results from the execute stage.
- It is the responder end of the fetch prediction/result protocol (pred_en/pred_pc/pred_taken, rslt_en/rslt_pc/rslt_taken).
- Holds a table of 2-bit saturating counters indexed by PC XOR global history.
- After reset, a sequential sweep initialises the table.

---
 rtl/gshare_pkg.sv | 21 ++
 rtl/gshare_predictor_if.sv | 26 ++
 rtl/gshare_index.sv | 29 ++
 rtl/gshare_predictor.sv | 97 +++++++++
 4 files changed

// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - shared types, constants and counter helpers for the gshare predictor
package gshare_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_WNT = 2'b01;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic cnt_t sat_dec(cnt_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// rtl/gshare_predictor_if.sv - fetch/execute prediction and result bus
interface gshare_predictor_if #(
  parameter int PC_W   = 15,
  parameter int HIST_W = 10
);

  logic              pred_en;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic              rslt_en;
  logic [PC_W-1:0]   rslt_pc;
  logic              rslt_taken;
  logic              ready;
  logic [HIST_W-1:0] ghr;

  modport master (
    output pred_en, pred_pc, rslt_en, rslt_pc, rslt_taken,
    input  pred_taken, ready, ghr
  );

  modport slave (
    input  pred_en, pred_pc, rslt_en, rslt_pc, rslt_taken,
    output pred_taken, ready, ghr
  );

endinterface

// File: rtl/gshare_index.sv
// rtl/gshare_index.sv - pc xor zero-extended global history table index
module gshare_index #(
  parameter int PC_W   = 15,
  parameter int IDX_W  = 10,
  parameter int HIST_W = 10
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [HIST_W-1:0] ghr,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] ghr_ext;

  // Zero-extend the history to index width, then hash with the low pc bits
  always_comb begin
    ghr_ext              = '0;
    ghr_ext[HIST_W-1:0]  = ghr;
    idx                  = pc[IDX_W-1:0] ^ ghr_ext;
  end

  // Upper pc bits do not participate in the hash
  generate
    if (PC_W > IDX_W) begin : g_upper
      logic unused_pc_hi;
      assign unused_pc_hi = ^pc[PC_W-1:IDX_W];
    end
  endgenerate

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch direction predictor with post-reset table sweep
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int PC_W   = 15,
  parameter int IDX_W  = 10,
  parameter int HIST_W = 10
) (
  input logic            clock,
  input logic            reset,
  gshare_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d, ghr_ins;
  cnt_t              cnt_table [ENTRIES];

  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  rslt_idx;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_waddr;
  cnt_t              tbl_wdata;
  cnt_t              upd_cnt;
  logic              ready_w;

  gshare_index #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W)) u_pred_index (
    .pc  (bus.pred_pc),
    .ghr (ghr_q),
    .idx (pred_idx)
  );

  gshare_index #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W)) u_rslt_index (
    .pc  (bus.rslt_pc),
    .ghr (ghr_q),
    .idx (rslt_idx)
  );

  // Control state: FSM, sweep pointer and committed history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ghr_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ghr_q     <= ghr_d;
    end
  end

  // Next state: sweep writes in CLEAR, resolved-branch training in READY
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ghr_d     = ghr_q;
    tbl_we    = 1'b0;
    tbl_waddr = clr_ptr_q;
    tbl_wdata = CNT_WNT;
    ghr_ins    = '0;
    ghr_ins[0] = bus.rslt_taken;
    upd_cnt    = cnt_table[rslt_idx];
    case (state_q)
      CLEAR: begin
        tbl_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) begin
          state_d = READY;
        end
      end
      READY: begin
        if (bus.rslt_en) begin
          tbl_we    = 1'b1;
          tbl_waddr = rslt_idx;
          tbl_wdata = bus.rslt_taken ? sat_inc(upd_cnt) : sat_dec(upd_cnt);
          ghr_d     = (ghr_q << 1) | ghr_ins;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Counter table write port; a write coinciding with reset is dropped
  always_ff @(posedge clock) begin
    if (!reset && tbl_we) begin
      cnt_table[tbl_waddr] <= tbl_wdata;
    end
  end

  assign ready_w        = (state_q == READY);
  assign bus.ready      = ready_w;
  assign bus.pred_taken = ready_w & bus.pred_en & cnt_table[pred_idx][1];
  assign bus.ghr        = ghr_q;

endmodule
